// File: rtl/dat_tx_pkg.sv
// dat_tx_pkg: shared definitions for the dat_tx serial transmitter.
//   state_t     - transmitter FSM states (idle, shifting a word, idle gap)
//   CNT_W       - width of the sent-word counter
//   bit_cnt_w() - bit-counter width for a given word width
//   gap_cnt_w() - gap-counter width for a given gap length
package dat_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Counter indexes bit positions 0..width-1; never narrower than one bit.
  function automatic int bit_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Counter indexes gap cycles 0..gap-1; a one-bit counter when gap is tiny or unused.
  function automatic int gap_cnt_w(input int gap);
    return (gap <= 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/dat_tx_if.sv
// dat_tx_if: parallel word load handshake into dat_tx.
//   load_data  - word to transmit (WIDTH bits)
//   load_valid - load_data is valid
//   load_ready - transmitter can accept a word this cycle
// Modports: master (word source), slave (dat_tx).
interface dat_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/dat_tx_shifter.sv
// dat_tx_shifter: WIDTH-bit load/shift register with a bit counter.
//   clk, reset - clock, synchronous active-low reset
//   load, data - capture a new word (wins over shift)
//   shift      - shift left by one, zero fill
//   msb        - current serial bit (register MSB)
//   last       - registered flag: msb is bit 0 of the current word
// Zero fill means the register is all zeros once a word has shifted out,
// so msb doubles as the idle/gap value of the serial line.
module dat_tx_shifter
  import dat_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             last
);

  localparam int CW = bit_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

  logic [WIDTH-1:0] sreg_r;
  logic [CW-1:0]    cnt_r;
  logic             last_r;

  // Shift register, bit position counter and last-bit flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_r <= '0;
      cnt_r  <= '0;
      last_r <= 1'b0;
    end else if (load) begin
      sreg_r <= data;
      cnt_r  <= '0;
      last_r <= 1'b0;
    end else if (shift) begin
      sreg_r <= {sreg_r[WIDTH-2:0], 1'b0};
      if (last_r) begin
        cnt_r  <= '0;
        last_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        last_r <= (cnt_r == CNT_PRE_LAST);
      end
    end else begin
      sreg_r <= sreg_r;
      cnt_r  <= cnt_r;
      last_r <= last_r;
    end
  end

  assign msb  = sreg_r[WIDTH-1];
  assign last = last_r;

endmodule

// File: rtl/dat_tx.sv
// dat_tx: serial bit-stream transmitter, MSB first, one bit per clock.
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset
//   load_if    - word load handshake (slave side)
//   DAT        - serial data line, 0 when idle or in gap
//   busy       - shifting a word or inserting gap cycles
//   done       - high during the cycle carrying bit 0 of a word
//   sent_count - words fully transmitted, modulo 16
// A one-word buffer lets a word be accepted while another is shifting, so
// with GAP=0 consecutive words leave no dead cycle on DAT.
module dat_tx
  import dat_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  dat_tx_if.slave          load_if,
  output logic             DAT,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int GCW = gap_cnt_w(GAP);
  localparam logic [GCW-1:0] GAP_LAST = (GAP > 0) ? GCW'(GAP - 1) : '0;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] buf_r;
  logic             buf_empty_r;
  logic [GCW-1:0]   gap_cnt_r;
  logic             busy_r;
  logic [CNT_W-1:0] count_r;

  logic             accept_s;
  logic             word_end_s;
  logic             gap_end_s;
  logic             free_s;
  logic             load_s;
  logic             shift_s;
  logic [WIDTH-1:0] load_word_s;
  logic             msb_s;
  logic             last_s;

  // Handshake and shifter-free decode. The shifter is free in IDLE, at the
  // end of a word when no gap follows, and on the final gap cycle; an
  // accept at any other time lands in the buffer. A full buffer blocks
  // accepts, so buffer and input never compete for the same load.
  always_comb begin
    accept_s    = load_if.load_valid & buf_empty_r;
    word_end_s  = (state_r == ST_SHIFT) & last_s;
    gap_end_s   = (state_r == ST_GAP) & (gap_cnt_r == GAP_LAST);
    free_s      = (state_r == ST_IDLE) | (word_end_s & (GAP == 0)) | gap_end_s;
    load_s      = free_s & (~buf_empty_r | accept_s);
    shift_s     = (state_r == ST_SHIFT) & ~load_s;
    if (!buf_empty_r) begin
      load_word_s = buf_r;
    end else begin
      load_word_s = load_if.load_data;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!last_s) begin
          state_nxt_s = ST_SHIFT;
        end else if (GAP > 0) begin
          state_nxt_s = ST_GAP;
        end else if (load_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (!gap_end_s) begin
          state_nxt_s = ST_GAP;
        end else if (load_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered busy, gap counter, holding buffer and sent counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      gap_cnt_r   <= '0;
      buf_r       <= '0;
      buf_empty_r <= 1'b1;
      count_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);

      if ((state_r == ST_GAP) && !gap_end_s) begin
        gap_cnt_r <= gap_cnt_r + GCW'(1);
      end else begin
        gap_cnt_r <= '0;
      end

      if (load_s && !buf_empty_r) begin
        buf_empty_r <= 1'b1;
      end else if (accept_s && !load_s) begin
        buf_r       <= load_if.load_data;
        buf_empty_r <= 1'b0;
      end else begin
        buf_r       <= buf_r;
        buf_empty_r <= buf_empty_r;
      end

      // last_s marks the bit-0 cycle of a word; the count steps as it ends.
      if (last_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  dat_tx_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .shift (shift_s),
    .data  (load_word_s),
    .msb   (msb_s),
    .last  (last_s)
  );

  assign load_if.load_ready = buf_empty_r;
  assign DAT                = msb_s;
  assign busy               = busy_r;
  assign done               = last_s;
  assign sent_count         = count_r;

endmodule

// File: tb/tb_dat_tx.sv
// tb_dat_tx: two dat_tx instances (GAP=0 and GAP=3) fed from independent
// word sources and checked every cycle against a transaction-level model:
// each accepted word gets a start cycle max(accept+1, previous start +
// WIDTH + GAP), and DAT/done/busy/load_ready/sent_count follow from the
// list of scheduled words.
module tb_dat_tx;

  localparam int WIDTH = 8;

  typedef struct packed {
    int         inst;
    int         start;
    logic [7:0] w;
  } ent_t;

  logic       clk;
  logic       reset;
  logic [1:0] dat_v;
  logic [1:0] done_v;
  logic [1:0] busy_v;
  logic [3:0] cnt0;
  logic [3:0] cnt1;

  dat_tx_if #(.WIDTH(WIDTH)) if0 ();
  dat_tx_if #(.WIDTH(WIDTH)) if1 ();

  dat_tx #(.WIDTH(WIDTH), .GAP(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .load_if    (if0),
    .DAT        (dat_v[0]),
    .busy       (busy_v[0]),
    .done       (done_v[0]),
    .sent_count (cnt0)
  );

  dat_tx #(.WIDTH(WIDTH), .GAP(3)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .load_if    (if1),
    .DAT        (dat_v[1]),
    .busy       (busy_v[1]),
    .done       (done_v[1]),
    .sent_count (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  int         cyc;
  bit         check_en;
  ent_t       sched_q[$];
  logic [7:0] src_q0[$];
  logic [7:0] src_q1[$];
  int         sent_m[2];
  int         last_start[2];

  // Counts a comparison and reports a mismatch.
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Expected outputs of instance i during the current cycle.
  task automatic model_out(input int i, output logic d, output logic dn,
                           output logic b, output logic r);
    logic [7:0] wv;
    int         s;
    d = 1'b0; dn = 1'b0; b = 1'b0; r = 1'b1;
    for (int k = 0; k < sched_q.size(); k++) begin
      if (sched_q[k].inst == i) begin
        s  = sched_q[k].start;
        wv = sched_q[k].w;
        if (cyc >= s && cyc < s + WIDTH) d = wv[WIDTH - 1 - (cyc - s)];
        if (cyc == s + WIDTH - 1) dn = 1'b1;
        if (cyc >= s && cyc < s + WIDTH + gap_of(i)) b = 1'b1;
        if (s > cyc) r = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input logic rst_v, input bit throttle);
    logic v [2];
    logic ed [2];
    logic edn [2];
    logic eb [2];
    logic er [2];
    ent_t e;
    int   s;
    @(posedge clk);
    #1;
    reset = rst_v;
    v[0] = rst_v && (src_q0.size() > 0) && (!throttle || $urandom_range(0, 3) != 0);
    v[1] = rst_v && (src_q1.size() > 0) && (!throttle || $urandom_range(0, 3) != 0);
    if0.load_valid = v[0];
    if1.load_valid = v[1];
    if0.load_data  = v[0] ? src_q0[0] : 8'($urandom);
    if1.load_data  = v[1] ? src_q1[0] : 8'($urandom);
    #3;
    for (int i = 0; i < 2; i++) begin
      model_out(i, ed[i], edn[i], eb[i], er[i]);
      if (check_en) begin
        chk($sformatf("g%0d.dat c%0d", gap_of(i), cyc), {7'd0, dat_v[i]}, {7'd0, ed[i]});
        chk($sformatf("g%0d.done c%0d", gap_of(i), cyc), {7'd0, done_v[i]}, {7'd0, edn[i]});
        chk($sformatf("g%0d.busy c%0d", gap_of(i), cyc), {7'd0, busy_v[i]}, {7'd0, eb[i]});
        chk($sformatf("g%0d.ready c%0d", gap_of(i), cyc),
            {7'd0, (i == 0) ? if0.load_ready : if1.load_ready}, {7'd0, er[i]});
        chk($sformatf("g%0d.sent c%0d", gap_of(i), cyc),
            {4'd0, (i == 0) ? cnt0 : cnt1}, 8'(sent_m[i]));
      end
    end
    if (!rst_v) begin
      sched_q.delete();
      src_q0.delete();
      src_q1.delete();
      sent_m[0] = 0; sent_m[1] = 0;
      last_start[0] = -100; last_start[1] = -100;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && er[i]) begin
          s = cyc + 1;
          if (last_start[i] + WIDTH + gap_of(i) > s) s = last_start[i] + WIDTH + gap_of(i);
          e.inst  = i;
          e.start = s;
          e.w     = (i == 0) ? src_q0[0] : src_q1[0];
          sched_q.push_back(e);
          last_start[i] = s;
          if (i == 0) void'(src_q0.pop_front());
          else        void'(src_q1.pop_front());
        end
        if (edn[i]) sent_m[i] = (sent_m[i] + 1) % 16;
      end
    end
    for (int k = sched_q.size() - 1; k >= 0; k--) begin
      if (sched_q[k].start + WIDTH + gap_of(sched_q[k].inst) <= cyc) sched_q.delete(k);
    end
    cyc++;
  endtask

  task automatic push_both(input logic [7:0] w);
    src_q0.push_back(w);
    src_q1.push_back(w);
  endtask

  // Runs until both sources and the schedule are empty, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0 || sched_q.size() > 0) && n < 600) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", {7'd0, (n >= 600)}, 8'd0);
    repeat (2) step(1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; check_en = 1'b0;
    reset = 1'b0;
    if0.load_valid = 1'b0; if0.load_data = 8'd0;
    if1.load_valid = 1'b0; if1.load_data = 8'd0;
    sent_m[0] = 0; sent_m[1] = 0;
    last_start[0] = -100; last_start[1] = -100;

    // Reset, then idle.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_en = 1'b1;
    repeat (6) step(1'b1, 1'b0);

    // Single word.
    push_both(8'hA6);
    drain();
    chk("single_sent_g0", {4'd0, cnt0}, 8'd1);

    // Back-to-back pair, and the same pair through the gap instance.
    push_both(8'hF0);
    push_both(8'h0F);
    drain();
    push_both(8'hFF);
    push_both(8'hFF);
    drain();
    chk("pairs_sent_g3", {4'd0, cnt1}, 8'd5);

    // Wrap-around of sent_count.
    step(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) push_both(8'(k * 13 + 1));
    drain();
    chk("wrap16_g0", {4'd0, cnt0}, 8'd0);
    chk("wrap16_g3", {4'd0, cnt1}, 8'd0);
    push_both(8'h3C);
    drain();
    chk("wrap17_g0", {4'd0, cnt0}, 8'd1);
    chk("wrap17_g3", {4'd0, cnt1}, 8'd1);

    // Reset mid-word with a word buffered, then a clean word.
    push_both(8'hFF);
    push_both(8'hAA);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midrst_dat_g0", {7'd0, dat_v[0]}, 8'd0);
    chk("midrst_sent_g0", {4'd0, cnt0}, 8'd0);
    push_both(8'h5A);
    drain();

    // Random traffic with throttled valid and rare resets.
    for (int c = 0; c < 500; c++) begin
      if (src_q0.size() < 3 && $urandom_range(0, 3) == 0) src_q0.push_back(8'($urandom));
      if (src_q1.size() < 3 && $urandom_range(0, 3) == 0) src_q1.push_back(8'($urandom));
      step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
